imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single combinational-read word memory (2**MEM_ADDR_SIZE words, byte address, word index = addr[MEM_ADDR_SIZE+1:2]) between two requesters:
  - port 0: instruction fetch.
  - port 1: program loader/debug, read or write.
- Round-robin arbitration with valid/ready request handshakes and registered one-cycle response pulses.
- Flags misaligned and out-of-range accesses without touching memory.
- Sits between the fetch stage/loader and the memory array.

Parameters:
DATA_WIDTH, 32, address/data width
MEM_ADDR_SIZE, 9, log2 of memory depth in words

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  port 0 read request
req0_addr  input  DATA_WIDTH  port 0 byte address
req0_ready  output  1  port 0 request accepted this cycle
req1_valid  input  1  port 1 request
req1_addr  input  DATA_WIDTH  port 1 byte address
req1_we  input  1  port 1 write enable (1 = write)
req1_wdata  input  DATA_WIDTH  port 1 write data
req1_ready  output  1  port 1 request accepted this cycle
resp0_valid  output  1  port 0 response pulse
resp0_data  output  DATA_WIDTH  port 0 read data
resp0_err  output  1  port 0 access error
resp1_valid  output  1  port 1 response pulse (reads and writes)
resp1_data  output  DATA_WIDTH  port 1 read data (0 for writes)
resp1_err  output  1  port 1 access error
mem_addr  output  MEM_ADDR_SIZE  word index to memory
mem_we  output  1  memory write strobe
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  combinational memory read data

Behaviour:
- Reset:
  - All resp_* outputs, mem_we and the priority pointer are 0; pointer 0 means port 0 is favoured.
  - req*_ready is 0 during reset.
  - Reset mid-operation drops any pending response; no response pulse in the cycle after reset.
- Arbitration (combinational, one grant per cycle):
  - If only one port is valid, that port is granted.
  - If both are valid, the port favoured by the pointer is granted.
  - On any grant, the pointer moves to favour the other port.
  - The pointer holds when idle.
  - req*_ready equals the grant for that port; a transfer occurs when valid && ready in the same cycle.
- Memory drive:
  - mem_addr is the granted addr[MEM_ADDR_SIZE+1:2]; when idle it is driven 0.
  - mem_we = granted port is 1 && req1_we && no error.
  - mem_wdata = req1_wdata.
- Error check:
  - Error when addr[1:0] != 0, or when any addr bit above MEM_ADDR_SIZE+1 is set.
  - An errored request is still accepted, with mem_we forced 0.
- Response latency: exactly 1 cycle.
  - At the edge after acceptance, resp<p>_valid=1 for one cycle.
  - resp<p>_data is mem_rdata sampled at acceptance, or 0 on error or write.
  - resp<p>_err reflects the error check.
  - In non-response cycles, data and err return to 0.
  - No response backpressure.
- Throughput: one transfer per cycle total. With both ports valid continuously, grants alternate 0,1,0,1.
- Write then read of the same word in consecutive cycles by either port returns the new data.
- A held request whose addr changes while not ready is legal; the value sampled at the grant cycle is used.

Optional Feature:
- Macro IMEM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins when both are valid, and the pointer is unused and held at 0. Port 1 is granted only in cycles where req0_valid=0.
- Undefined: round-robin as above.

Test Plan:
- Reset held 2 cycles with both req valid -> req0_ready=req1_ready=0, all resp_*=0. First cycle after reset grants port 0.
- Port1 write addr 0x10 data 0xDEADBEEF, then port0 read 0x10 -> mem_we=1 with mem_addr=4. One cycle later resp1_valid=1, resp1_data=0. Next cycle resp0_data=0xDEADBEEF, resp0_err=0.
- Both ports valid for 6 cycles -> grants alternate 0,1,0,1,0,1, starting with the pointer's port. Each resp pulses the cycle after its grant.
- Port1 write addr 0x12 (misaligned), then addr 0x800 with MEM_ADDR_SIZE=9 (out of range) -> mem_we stays 0, resp1_err=1 both times, memory contents unchanged on readback.
- Both ports valid with IMEM_ARB_FIXED_PRIO_EN defined -> port 0 granted every cycle and req1_ready=0. Drop req0_valid -> port 1 granted the same cycle.
- Assert reset in the cycle after a grant -> no resp pulse appears, and the pointer returns to favour port 0.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Shares one combinational-read word memory between instruction fetch (port 0) and loader/debug (port 1).
// Round-robin by default; define IMEM_ARB_FIXED_PRIO_EN to give port 0 fixed priority.
module imem_port_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_ADDR_SIZE = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0_valid,
  input  logic [DATA_WIDTH-1:0]    req0_addr,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [DATA_WIDTH-1:0]    req1_addr,
  input  logic                     req1_we,
  input  logic [DATA_WIDTH-1:0]    req1_wdata,
  output logic                     req1_ready,
  output logic                     resp0_valid,
  output logic [DATA_WIDTH-1:0]    resp0_data,
  output logic                     resp0_err,
  output logic                     resp1_valid,
  output logic [DATA_WIDTH-1:0]    resp1_data,
  output logic                     resp1_err,
  output logic [MEM_ADDR_SIZE-1:0] mem_addr,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  // First byte-address bit that lies beyond the memory array.
  localparam int HI = MEM_ADDR_SIZE + 2;

  logic oor0, oor1;
  logic err0, err1;

  generate
    if (DATA_WIDTH > HI) begin : g_oor
      assign oor0 = |req0_addr[DATA_WIDTH-1:HI];
      assign oor1 = |req1_addr[DATA_WIDTH-1:HI];
    end else begin : g_no_oor
      assign oor0 = 1'b0;
      assign oor1 = 1'b0;
    end
  endgenerate

  assign err0 = (req0_addr[1:0] != 2'b00) | oor0;
  assign err1 = (req1_addr[1:0] != 2'b00) | oor1;

  logic ptr_q, ptr_d;
  logic gnt0, gnt1;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
`ifdef IMEM_ARB_FIXED_PRIO_EN
      gnt0 = req0_valid;
      gnt1 = req1_valid & ~req0_valid;
`else
      if (req0_valid && req1_valid) begin
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
`endif
    end
  end

`ifdef IMEM_ARB_FIXED_PRIO_EN
  assign ptr_d = 1'b0;
`else
  // After a grant the other port is favoured; the pointer holds when idle.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt0) begin
      ptr_d = 1'b1;
    end else if (gnt1) begin
      ptr_d = 1'b0;
    end
  end
`endif

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    mem_addr = '0;
    if (gnt0) begin
      mem_addr = req0_addr[HI-1:2];
    end else if (gnt1) begin
      mem_addr = req1_addr[HI-1:2];
    end
  end

  assign mem_we    = gnt1 & req1_we & ~err1;
  assign mem_wdata = req1_wdata;

  logic                  rv0_q, rv0_d, re0_q, re0_d;
  logic                  rv1_q, rv1_d, re1_q, re1_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;

  always_comb begin
    rv0_d = gnt0;
    re0_d = gnt0 & err0;
    rd0_d = (gnt0 && !err0) ? mem_rdata : '0;
    rv1_d = gnt1;
    re1_d = gnt1 & err1;
    rd1_d = (gnt1 && !err1 && !req1_we) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
      rv0_q <= 1'b0;
      re0_q <= 1'b0;
      rd0_q <= '0;
      rv1_q <= 1'b0;
      re1_q <= 1'b0;
      rd1_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rv0_q <= rv0_d;
      re0_q <= re0_d;
      rd0_q <= rd0_d;
      rv1_q <= rv1_d;
      re1_q <= re1_d;
      rd1_q <= rd1_d;
    end
  end

  // Masking with reset drops a response that was registered just before reset asserted.
  assign resp0_valid = rv0_q & ~reset;
  assign resp0_err   = re0_q & ~reset;
  assign resp0_data  = reset ? '0 : rd0_q;
  assign resp1_valid = rv1_q & ~reset;
  assign resp1_err   = re1_q & ~reset;
  assign resp1_data  = reset ? '0 : rd1_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Self-checking bench for imem_port_arbiter: directed vector table, corner sequences,
// then randomized traffic against a behavioural model (honours IMEM_ARB_FIXED_PRIO_EN).
module tb_imem_port_arbiter;
  localparam int DW    = 32;
  localparam int MAS   = 9;
  localparam int DEPTH = 1 << MAS;

  typedef struct {
    logic          v0;
    logic [DW-1:0] a0;
    logic          v1;
    logic [DW-1:0] a1;
    logic          we;
    logic [DW-1:0] wd;
    logic          rdy0;
    logic          rdy1;
    logic          mwe;
    logic [MAS-1:0] maddr;
    logic          rv0;
    logic [DW-1:0] rd0;
    logic          re0;
    logic          rv1;
    logic [DW-1:0] rd1;
    logic          re1;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req0_ready, req1_valid, req1_we, req1_ready;
  logic [DW-1:0] req0_addr, req1_addr, req1_wdata;
  logic resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [DW-1:0] resp0_data, resp1_data;
  logic [MAS-1:0] mem_addr;
  logic mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  imem_port_arbiter #(.DATA_WIDTH(DW), .MEM_ADDR_SIZE(MAS)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_we(req1_we),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_err(resp1_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int i);
    return 32'hA500_0000 | 32'(i);
  endfunction

  // Memory array attached to the arbiter
  logic init_mem;
  logic [DW-1:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Reference model state
  logic [DW-1:0] ref_mem [DEPTH];
  int last_gnt;
  logic p0_v, p0_e, p1_v, p1_e;
  logic [DW-1:0] p0_d, p1_d;
  int checks, errors;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bad(input logic [DW-1:0] a);
    return ((a % 4) != 0) || (a >= 32'(DEPTH * 4));
  endfunction

  function automatic vec_t mk(input logic v0, input logic [DW-1:0] a0, input logic v1,
                              input logic [DW-1:0] a1, input logic we, input logic [DW-1:0] wd,
                              input logic rdy0, input logic rdy1, input logic mwe,
                              input logic [MAS-1:0] maddr,
                              input logic rv0, input logic [DW-1:0] rd0, input logic re0,
                              input logic rv1, input logic [DW-1:0] rd1, input logic re1);
    vec_t v;
    v.v0 = v0; v.a0 = a0; v.v1 = v1; v.a1 = a1; v.we = we; v.wd = wd;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.mwe = mwe; v.maddr = maddr;
    v.rv0 = rv0; v.rd0 = rd0; v.re0 = re0; v.rv1 = rv1; v.rd1 = rd1; v.re1 = re1;
    return v;
  endfunction

  // One normal cycle: drive, compare (table or model), advance the model.
  task automatic cycle(input vec_t v, input bit use_tab);
    bit fav1, g0, g1, n0e, n1e;
    logic [DW-1:0] n0d, n1d;
    int idx;
    logic e_rdy0, e_rdy1, e_mwe, e_rv0, e_re0, e_rv1, e_re1;
    logic [MAS-1:0] e_maddr;
    logic [DW-1:0] e_rd0, e_rd1;
    req0_valid = v.v0; req0_addr = v.a0;
    req1_valid = v.v1; req1_addr = v.a1; req1_we = v.we; req1_wdata = v.wd;
`ifdef IMEM_ARB_FIXED_PRIO_EN
    fav1 = 1'b0;
`else
    fav1 = (last_gnt == 0);
`endif
    g0  = v.v0 && !(v.v1 && fav1);
    g1  = v.v1 && !g0;
    idx = g0 ? int'(v.a0 / 4) % DEPTH : (g1 ? int'(v.a1 / 4) % DEPTH : 0);
    if (use_tab) begin
      e_rdy0 = v.rdy0; e_rdy1 = v.rdy1; e_mwe = v.mwe; e_maddr = v.maddr;
      e_rv0 = v.rv0; e_rd0 = v.rd0; e_re0 = v.re0;
      e_rv1 = v.rv1; e_rd1 = v.rd1; e_re1 = v.re1;
    end else begin
      e_rdy0 = g0; e_rdy1 = g1; e_mwe = g1 && v.we && !bad(v.a1); e_maddr = MAS'(idx);
      e_rv0 = p0_v; e_rd0 = p0_d; e_re0 = p0_e;
      e_rv1 = p1_v; e_rd1 = p1_d; e_re1 = p1_e;
    end
    @(negedge clk);
    check1("req0_ready", req0_ready, e_rdy0);
    check1("req1_ready", req1_ready, e_rdy1);
    check1("mem_we", mem_we, e_mwe);
    checkw("mem_addr", DW'(mem_addr), DW'(e_maddr));
    check1("resp0_valid", resp0_valid, e_rv0);
    checkw("resp0_data", resp0_data, e_rd0);
    check1("resp0_err", resp0_err, e_re0);
    check1("resp1_valid", resp1_valid, e_rv1);
    checkw("resp1_data", resp1_data, e_rd1);
    check1("resp1_err", resp1_err, e_re1);
    n0e = g0 && bad(v.a0);
    n0d = (g0 && !n0e) ? ref_mem[idx] : '0;
    n1e = g1 && bad(v.a1);
    n1d = (g1 && !n1e && !v.we) ? ref_mem[idx] : '0;
    if (g1 && v.we && !n1e) ref_mem[idx] = v.wd;
    if (g0) last_gnt = 0;
    else if (g1) last_gnt = 1;
    @(posedge clk); #1;
    p0_v = g0; p0_d = n0d; p0_e = n0e;
    p1_v = g1; p1_d = n1d; p1_e = n1e;
  endtask

  // A reset cycle with both ports requesting (port 1 writing).
  task automatic reset_cycle(input logic [DW-1:0] a);
    reset = 1'b1;
    req0_valid = 1'b1; req0_addr = a;
    req1_valid = 1'b1; req1_addr = a; req1_we = 1'b1; req1_wdata = $urandom;
    @(negedge clk);
    check1("rst_req0_ready", req0_ready, 1'b0);
    check1("rst_req1_ready", req1_ready, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check1("rst_resp0_valid", resp0_valid, 1'b0);
    checkw("rst_resp0_data", resp0_data, '0);
    check1("rst_resp0_err", resp0_err, 1'b0);
    check1("rst_resp1_valid", resp1_valid, 1'b0);
    checkw("rst_resp1_data", resp1_data, '0);
    check1("rst_resp1_err", resp1_err, 1'b0);
    p0_v = 1'b0; p0_d = '0; p0_e = 1'b0;
    p1_v = 1'b0; p1_d = '0; p1_e = 1'b0;
    last_gnt = 1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_addr();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 32'($urandom_range(0, 63));
    if (r == 1) return 32'h800 + 32'($urandom_range(0, 7)) * 4;
    return 32'($urandom_range(0, 7)) * 4;
  endfunction

  function automatic vec_t rnd_vec(input bit both);
    return mk(both ? 1'b1 : ($urandom_range(0, 2) != 0), rnd_addr(),
              both ? 1'b1 : ($urandom_range(0, 2) != 0), rnd_addr(),
              1'($urandom_range(0, 1)), $urandom,
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  vec_t tab [10];

  initial begin
    checks = 0; errors = 0;
    init_mem = 1'b1; reset = 1'b1;
    req0_valid = 1'b0; req0_addr = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_we = 1'b0; req1_wdata = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
    last_gnt = 1;
    p0_v = 1'b0; p0_d = '0; p0_e = 1'b0;
    p1_v = 1'b0; p1_d = '0; p1_e = 1'b0;

    //        v0 a0     v1 a1      we wd            rdy0 rdy1 mwe maddr rv0 rd0           re0 rv1 rd1           re1
    tab[0] = mk(1, 'h8,  1, 'hC,   0, 0,            1, 0, 0, 2, 0, 0,            0, 0, 0,            0);
    tab[1] = mk(0, 0,    1, 'h10,  1, 'hDEADBEEF,   0, 1, 1, 4, 1, 'hA5000002,   0, 0, 0,            0);
    tab[2] = mk(1, 'h10, 0, 0,     0, 0,            1, 0, 0, 4, 0, 0,            0, 1, 0,            0);
    tab[3] = mk(0, 0,    0, 0,     0, 0,            0, 0, 0, 0, 1, 'hDEADBEEF,   0, 0, 0,            0);
    tab[4] = mk(0, 0,    1, 'h12,  1, 'h11111111,   0, 1, 0, 4, 0, 0,            0, 0, 0,            0);
    tab[5] = mk(0, 0,    1, 'h800, 1, 'h22222222,   0, 1, 0, 0, 0, 0,            0, 1, 0,            1);
    tab[6] = mk(0, 0,    1, 'h10,  0, 0,            0, 1, 0, 4, 0, 0,            0, 1, 0,            1);
    tab[7] = mk(1, 'h0,  0, 0,     0, 0,            1, 0, 0, 0, 0, 0,            0, 1, 'hDEADBEEF,   0);
    tab[8] = mk(1, 'h3,  0, 0,     0, 0,            1, 0, 0, 0, 1, 'hA5000000,   0, 0, 0,            0);
    tab[9] = mk(0, 0,    0, 0,     0, 0,            0, 0, 0, 0, 1, 0,            1, 0, 0,            0);

    @(posedge clk); #1;
    reset_cycle('h20);
    reset_cycle('h24);
    init_mem = 1'b0;

    for (int i = 0; i < 10; i++) cycle(tab[i], 1'b1);

    // Six cycles of contention: grants alternate (round-robin) or stay on port 0 (fixed).
    for (int i = 0; i < 6; i++) cycle(rnd_vec(1'b1), 1'b0);
    cycle(mk(0, 0, 1, 'h14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    // Reset right after a grant drops the response and re-favours port 0.
    cycle(mk(1, 'h4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    reset_cycle('h8);
    cycle(mk(1, 'h8, 1, 'hC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) reset_cycle(rnd_addr());
      else cycle(rnd_vec(($urandom_range(0, 3) == 0)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
